lsu_arb: RTL and testbench

Parametrised, registered successor to the core's load/store unit arbitration. It arbitrates NCH requester channels onto a shared memory path and decodes the granted address to either the tightly-coupled SRAM or the AXI master. It tracks one outstanding transaction and routes the response back to the originating channel. It sits between the fetch/AGU/AXI-slave requesters and the SRAM/AXI-master ports.

---
 rtl/lsu_arb_pkg.sv | 17 +
 rtl/lsu_arb_gnt.sv | 28 ++
 rtl/lsu_arb.sv | 183 ++++++++++++++++++
 tb/tb_lsu_arb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: FSM state encodings, SRAM window default and helpers
// shared by the lsu_arb block and its grant sub-module.
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic [15:0] SRAM_HI_DEF = 16'h8000;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsu_arb_gnt.sv
// lsu_arb_gnt: one-hot grant from the request vector, searching from
// ptr+1 and wrapping; a pointer held at NCH-1 gives fixed priority.
module lsu_arb_gnt
    import lsu_arb_pkg::*;
#(
    parameter int NCH = 3,
    parameter int IW  = idx_w(NCH)
) (
    input  logic [NCH-1:0] val,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt
);

    logic hit;

    // First asserted channel after the pointer wins.
    always_comb begin
        gnt = '0;
        hit = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            if (!hit && val[(int'(ptr) + i) % NCH]) begin
                gnt[(int'(ptr) + i) % NCH] = 1'b1;
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_arb.sv
// lsu_arb: NCH-channel arbiter onto SRAM / AXI-master, one outstanding op.
// LSU_ARB_RR_EN selects round-robin; otherwise fixed priority (ch0 first).
module lsu_arb
    import lsu_arb_pkg::*;
#(
    parameter int          NCH     = 3,
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter logic [15:0] SRAM_HI = SRAM_HI_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    i_req_val,
    output logic [NCH-1:0]    o_req_rdy,
    input  logic [NCH*AW-1:0] i_req_adr,
    input  logic [NCH*DW-1:0] i_req_wdat,
    input  logic [NCH*DW/8-1:0] i_req_wen,
    input  logic [NCH-1:0]    i_req_ren,
    output logic [NCH-1:0]    o_rsp_val,
    output logic [DW-1:0]     o_rsp_rdat,
    output logic [AW-1:0]     o_adr,
    output logic [DW-1:0]     o_wdat,
    output logic [DW/8-1:0]   o_wen,
    output logic              o_ren,
    output logic              o_sram_val,
    input  logic              i_sram_rdy,
    input  logic              i_sram_rvld,
    input  logic [DW-1:0]     i_sram_rdat,
    output logic              o_axim_val,
    input  logic              i_axim_rdy,
    input  logic              i_axim_rvld,
    input  logic [DW-1:0]     i_axim_rdat
);

    localparam int IW = idx_w(NCH);
    localparam int BW = DW / 8;

    state_t          state;
    state_t          state_nx;
    logic [NCH-1:0]  gnt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt_id;
    logic [IW-1:0]   id_q;
    logic [IW-1:0]   rsp_id;
    logic [AW-1:0]   acc_adr;
    logic [AW-1:0]   adr_q;
    logic [DW-1:0]   acc_wdat;
    logic [DW-1:0]   wdat_q;
    logic [DW-1:0]   rdat_q;
    logic [BW-1:0]   acc_wen;
    logic [BW-1:0]   wen_q;
    logic [NCH-1:0]  rsp_q;
    logic            acc_ren;
    logic            acc;
    logic            acc_wr;
    logic            acc_rd;
    logic            ren_q;
    logic            sel_q;
    logic            in_req;
    logic            tgt_rdy;
    logic            tgt_rvld;
    logic            rsp_fire;

    lsu_arb_gnt #(
        .NCH (NCH),
        .IW  (IW)
    ) u_gnt (
        .val (i_req_val),
        .ptr (ptr),
        .gnt (gnt)
    );

    // Encode the winner and mux its payload out of the packed buses.
    always_comb begin
        gnt_id = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt[k]) gnt_id = IW'(k);
        end
        acc_adr  = i_req_adr[gnt_id*AW +: AW];
        acc_wdat = i_req_wdat[gnt_id*DW +: DW];
        acc_wen  = i_req_wen[gnt_id*BW +: BW];
        acc_ren  = i_req_ren[gnt_id];
    end

    // No grant is shown while reset is held, so nobody sees a false accept.
    assign acc       = rst_n && (state == IDLE) && (gnt != '0);
    assign acc_wr    = |acc_wen;
    assign acc_rd    = acc_ren && !acc_wr;
    assign o_req_rdy = acc ? gnt : '0;

    assign tgt_rdy  = sel_q ? i_sram_rdy  : i_axim_rdy;
    assign tgt_rvld = sel_q ? i_sram_rvld : i_axim_rvld;

    // Next state and completion trigger.
    always_comb begin
        state_nx = state;
        rsp_fire = 1'b0;
        rsp_id   = id_q;
        unique case (state)
            IDLE: begin
                rsp_id = gnt_id;
                if (acc && (acc_wr || acc_rd)) state_nx = REQ;
                else if (acc) rsp_fire = 1'b1;
            end
            REQ: begin
                if (tgt_rdy) begin
                    if (wen_q != '0) begin
                        state_nx = IDLE;
                        rsp_fire = 1'b1;
                    end else begin
                        state_nx = RSP;
                    end
                end
            end
            RSP: begin
                if (tgt_rvld) begin
                    state_nx = IDLE;
                    rsp_fire = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Latch the accepted request; a write with ren set stays a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q   <= '0;
            adr_q  <= '0;
            wdat_q <= '0;
            wen_q  <= '0;
            ren_q  <= 1'b0;
            sel_q  <= 1'b0;
        end else if (acc) begin
            id_q   <= gnt_id;
            adr_q  <= acc_adr;
            wdat_q <= acc_wdat;
            wen_q  <= acc_wen;
            ren_q  <= acc_rd;
            sel_q  <= (acc_adr[AW-1 -: 16] == SRAM_HI);
        end
    end

    // One-cycle completion pulse and read data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q  <= '0;
            rdat_q <= '0;
        end else begin
            rsp_q <= rsp_fire ? (NCH'(1) << rsp_id) : '0;
            if (state == RSP && tgt_rvld)
                rdat_q <= sel_q ? i_sram_rdat : i_axim_rdat;
        end
    end

`ifdef LSU_ARB_RR_EN
    // Round-robin pointer follows the last accepted channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ptr <= IW'(NCH - 1);
        else if (acc) ptr <= gnt_id;
    end
`else
    assign ptr = IW'(NCH - 1);
`endif

    // Downstream bus is driven only while a request is pending.
    assign in_req     = (state == REQ);
    assign o_sram_val = in_req && sel_q;
    assign o_axim_val = in_req && !sel_q;
    assign o_adr      = in_req ? adr_q  : '0;
    assign o_wdat     = in_req ? wdat_q : '0;
    assign o_wen      = in_req ? wen_q  : '0;
    assign o_ren      = in_req && ren_q;
    assign o_rsp_val  = rsp_q;
    assign o_rsp_rdat = rdat_q;

endmodule

// File: tb/tb_lsu_arb.sv
// tb_lsu_arb: scenario tasks plus randomized traffic checked against a
// transaction-level timing model of the arbiter.
module tb_lsu_arb;

    localparam int NCH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_val, req_ren, o_req_rdy, o_rsp_val;
    logic [95:0] req_adr, req_wdat;
    logic [11:0] req_wen;
    logic [31:0] o_rsp_rdat, o_adr, o_wdat, sram_rdat, axim_rdat;
    logic [3:0]  o_wen;
    logic        o_ren, o_sram_val, o_axim_val;
    logic        sram_rdy, sram_rvld, axim_rdy, axim_rvld;

    int vec = 0;
    int err = 0;
    int last = NCH - 1;

    always #5 clk = ~clk;

    lsu_arb dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_val(req_val), .o_req_rdy(o_req_rdy),
        .i_req_adr(req_adr), .i_req_wdat(req_wdat),
        .i_req_wen(req_wen), .i_req_ren(req_ren),
        .o_rsp_val(o_rsp_val), .o_rsp_rdat(o_rsp_rdat),
        .o_adr(o_adr), .o_wdat(o_wdat), .o_wen(o_wen), .o_ren(o_ren),
        .o_sram_val(o_sram_val), .i_sram_rdy(sram_rdy),
        .i_sram_rvld(sram_rvld), .i_sram_rdat(sram_rdat),
        .o_axim_val(o_axim_val), .i_axim_rdy(axim_rdy),
        .i_axim_rvld(axim_rvld), .i_axim_rdat(axim_rdat)
    );

    // Reference arbitration: who wins given the requesting set.
    function automatic int pick(input logic [2:0] v, input int lst);
        if (lst >= NCH) return -1;
`ifdef LSU_ARB_RR_EN
        for (int j = 1; j <= NCH; j++)
            if (v[(lst + j) % NCH]) return (lst + j) % NCH;
`else
        for (int j = 0; j < NCH; j++)
            if (v[j]) return j;
`endif
        return -1;
    endfunction

    task automatic quiet();
        req_val = '0;
        req_adr = {$urandom, $urandom, $urandom};
        req_wdat = {$urandom, $urandom, $urandom};
        req_wen = 12'($urandom);
        req_ren = 3'($urandom);
        sram_rdy = 0; sram_rvld = 0; axim_rdy = 0; axim_rvld = 0;
        sram_rdat = $urandom; axim_rdat = $urandom;
    endtask

    // One isolated transaction; expectations come from the latency rules.
    task automatic run_txn(input int ch, input logic [31:0] adr,
                           input logic [31:0] wdat, input logic [3:0] wen,
                           input logic ren, input int rdy_d, input int rvld_d,
                           input logic [31:0] rdat);
        logic wr, rd, sr, act, s_rdy, s_rvld;
        logic [2:0] one, e_rsp, e_rdy;
        int t_rv, t_pl;
        wr = (wen != 0);
        rd = !wr && ren;
        sr = (adr[31:16] == 16'h8000);
        one = 3'(1 << ch);
        t_rv = 2 + rdy_d + rvld_d;
        t_pl = wr ? 2 + rdy_d : (rd ? t_rv + 1 : 1);
        for (int t = 0; t <= t_pl; t++) begin
            @(negedge clk);
            quiet();
            if (t == 0) begin
                req_val = one;
                req_adr[ch*32 +: 32] = adr;
                req_wdat[ch*32 +: 32] = wdat;
                req_wen[ch*4 +: 4] = wen;
                req_ren[ch] = ren;
            end
            act = (wr || rd) && t >= 1 && t <= 1 + rdy_d;
            s_rdy = act && (t == 1 + rdy_d);
            s_rvld = rd && (t == t_rv);
            sram_rdy = sr ? s_rdy : 1'($urandom);
            axim_rdy = sr ? 1'($urandom) : s_rdy;
            sram_rvld = sr ? s_rvld : 1'($urandom);
            axim_rvld = sr ? 1'($urandom) : s_rvld;
            if (s_rvld && sr) sram_rdat = rdat;
            if (s_rvld && !sr) axim_rdat = rdat;
            #1;
            e_rdy = (t == 0) ? one : 3'b000;
            e_rsp = (t == t_pl) ? one : 3'b000;
            vec++; if (o_req_rdy !== e_rdy) begin err++; $display("FAIL txn_rdy t=%0d: got %b want %b", t, o_req_rdy, e_rdy); end
            vec++; if (o_sram_val !== (act && sr)) begin err++; $display("FAIL txn_sram_val t=%0d: got %b want %b", t, o_sram_val, act && sr); end
            vec++; if (o_axim_val !== (act && !sr)) begin err++; $display("FAIL txn_axim_val t=%0d: got %b want %b", t, o_axim_val, act && !sr); end
            vec++; if (o_adr !== (act ? adr : 32'h0)) begin err++; $display("FAIL txn_adr t=%0d: got %h want %h", t, o_adr, act ? adr : 32'h0); end
            vec++; if (o_wdat !== (act ? wdat : 32'h0)) begin err++; $display("FAIL txn_wdat t=%0d: got %h want %h", t, o_wdat, act ? wdat : 32'h0); end
            vec++; if (o_wen !== (act ? wen : 4'h0)) begin err++; $display("FAIL txn_wen t=%0d: got %h want %h", t, o_wen, act ? wen : 4'h0); end
            vec++; if (o_ren !== (act && rd)) begin err++; $display("FAIL txn_ren t=%0d: got %b want %b", t, o_ren, act && rd); end
            vec++; if (o_rsp_val !== e_rsp) begin err++; $display("FAIL txn_rsp_val t=%0d: got %b want %b", t, o_rsp_val, e_rsp); end
            if (t == t_pl && rd) begin
                vec++; if (o_rsp_rdat !== rdat) begin err++; $display("FAIL txn_rdat: got %h want %h", o_rsp_rdat, rdat); end
            end
        end
        last = ch;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        req_val = '1; req_ren = '1; req_wen = '1;
        req_adr = {$urandom, $urandom, $urandom};
        req_wdat = {$urandom, $urandom, $urandom};
        sram_rdy = 1; sram_rvld = 1; axim_rdy = 1; axim_rvld = 1;
        sram_rdat = $urandom; axim_rdat = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            vec++; if ({o_req_rdy, o_rsp_val, o_rsp_rdat, o_adr, o_wdat, o_wen, o_ren, o_sram_val, o_axim_val} !== '0) begin
                err++; $display("FAIL reset_outputs: rdy=%b rsp=%b adr=%h val=%b%b", o_req_rdy, o_rsp_val, o_adr, o_sram_val, o_axim_val);
            end
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        vec++; if (o_req_rdy !== 3'b001) begin err++; $display("FAIL reset_first_gnt: got %b want 001", o_req_rdy); end
        @(negedge clk);
        quiet();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        last = NCH - 1;
    endtask

    task automatic test_arb_order();
        int seq [4];
        int prev;
`ifdef LSU_ARB_RR_EN
        seq = '{0, 1, 2, 0};
`else
        seq = '{0, 0, 0, 0};
`endif
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            quiet();
            req_val = 3'b111; req_wen = '0; req_ren = '0;
            #1;
            vec++; if (o_req_rdy !== 3'(1 << seq[k])) begin err++; $display("FAIL arb_order k=%0d: got %b want %b", k, o_req_rdy, 3'(1 << seq[k])); end
            if (prev >= 0) begin
                vec++; if (o_rsp_val !== 3'(1 << prev)) begin err++; $display("FAIL arb_null_rsp k=%0d: got %b want %b", k, o_rsp_val, 3'(1 << prev)); end
            end
            vec++; if (o_sram_val || o_axim_val) begin err++; $display("FAIL arb_null_val k=%0d: got %b%b want 00", k, o_sram_val, o_axim_val); end
            prev = seq[k];
            last = seq[k];
        end
        @(negedge clk);
        quiet();
        #1;
        vec++; if (o_rsp_val !== 3'(1 << prev)) begin err++; $display("FAIL arb_last_rsp: got %b want %b", o_rsp_val, 3'(1 << prev)); end
    endtask

    task automatic test_back_to_back();
        run_txn(0, 32'h4000_0000, 32'h1234_5678, 4'b1111, 1'b0, 0, 0, 32'h0);
        @(negedge clk);
        quiet();
        req_val = 3'b001; req_adr[31:0] = 32'h4000_0004;
        req_wen[3:0] = 4'hf; req_ren[0] = 1'b0;
        #1;
        vec++; if (o_req_rdy !== 3'b001) begin err++; $display("FAIL b2b_gnt0: got %b want 001", o_req_rdy); end
        @(negedge clk);
        quiet();
        axim_rdy = 1;
        #1;
        vec++; if (o_axim_val !== 1'b1) begin err++; $display("FAIL b2b_axim_val: got %b want 1", o_axim_val); end
        @(negedge clk);
        quiet();
        req_val = 3'b010; req_wen[7:4] = 4'h0; req_ren[1] = 1'b0;
        #1;
        vec++; if (o_rsp_val !== 3'b001) begin err++; $display("FAIL b2b_rsp0: got %b want 001", o_rsp_val); end
        vec++; if (o_req_rdy !== 3'b010) begin err++; $display("FAIL b2b_gnt1: got %b want 010", o_req_rdy); end
        @(negedge clk);
        quiet();
        #1;
        vec++; if (o_rsp_val !== 3'b010) begin err++; $display("FAIL b2b_rsp1: got %b want 010", o_rsp_val); end
        last = 1;
    endtask

    task automatic test_reset_rsp();
        @(negedge clk);
        quiet();
        req_val = 3'b001; req_adr[31:0] = 32'h8000_0000;
        req_wen[3:0] = 4'h0; req_ren[0] = 1'b1;
        #1;
        vec++; if (o_req_rdy !== 3'b001) begin err++; $display("FAIL rrsp_gnt: got %b want 001", o_req_rdy); end
        @(negedge clk);
        quiet();
        sram_rdy = 1;
        #1;
        vec++; if (o_sram_val !== 1'b1) begin err++; $display("FAIL rrsp_sram_val: got %b want 1", o_sram_val); end
        @(negedge clk);
        quiet();
        #1;
        vec++; if (o_sram_val !== 1'b0) begin err++; $display("FAIL rrsp_in_rsp: got %b want 0", o_sram_val); end
        rst_n = 0;
        #1;
        vec++; if ({o_req_rdy, o_rsp_val, o_sram_val, o_axim_val, o_adr} !== '0) begin err++; $display("FAIL rrsp_reset_out: rsp=%b adr=%h", o_rsp_val, o_adr); end
        @(negedge clk);
        quiet();
        rst_n = 1;
        sram_rvld = 1; axim_rvld = 1;
        #1;
        vec++; if (o_rsp_val !== 3'b000) begin err++; $display("FAIL rrsp_no_pulse: got %b want 000", o_rsp_val); end
        last = NCH - 1;
        @(negedge clk);
        quiet();
        req_val = 3'b100; req_wen[11:8] = 4'h0; req_ren[2] = 1'b0;
        #1;
        vec++; if (o_rsp_val !== 3'b000) begin err++; $display("FAIL rrsp_late_rvld: got %b want 000", o_rsp_val); end
        vec++; if (o_req_rdy !== 3'b100) begin err++; $display("FAIL rrsp_idle_gnt: got %b want 100", o_req_rdy); end
        @(negedge clk);
        quiet();
        #1;
        vec++; if (o_rsp_val !== 3'b100) begin err++; $display("FAIL rrsp_null_rsp: got %b want 100", o_rsp_val); end
        last = 2;
    endtask

    task automatic test_random_arb();
        logic [2:0] v;
        int w, prev;
        prev = -1;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            quiet();
            v = (k == 30) ? 3'b000 : 3'($urandom_range(0, 7));
            req_val = v; req_wen = '0; req_ren = '0;
            #1;
            w = pick(v, last);
            vec++; if (o_req_rdy !== ((w < 0) ? 3'b000 : 3'(1 << w))) begin err++; $display("FAIL rand_arb_gnt k=%0d v=%b: got %b want %0d", k, v, o_req_rdy, w); end
            vec++; if (o_rsp_val !== ((prev < 0) ? 3'b000 : 3'(1 << prev))) begin err++; $display("FAIL rand_arb_rsp k=%0d: got %b want %0d", k, o_rsp_val, prev); end
            if (w >= 0) last = w;
            prev = w;
        end
    endtask

    task automatic test_random_txn();
        int ch;
        logic [31:0] adr;
        logic [3:0] wen;
        for (int n = 0; n < 40; n++) begin
            ch = $urandom_range(0, 2);
            adr = {($urandom_range(0, 1) == 1) ? 16'h8000 : 16'($urandom), 16'($urandom)};
            wen = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            run_txn(ch, adr, $urandom, wen, 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        quiet();
        test_reset();
        test_arb_order();
        run_txn(1, 32'h8000_0010, 32'h0, 4'h0, 1'b1, 2, 2, 32'hDEAD_BEEF);
        run_txn(2, 32'h4000_0000, 32'hCAFE_F00D, 4'b0011, 1'b0, 0, 0, 32'h0);
        run_txn(0, 32'h8000_0100, 32'h5555_AAAA, 4'b1000, 1'b1, 1, 0, 32'h0);
        run_txn(1, 32'h1234_0000, 32'h0, 4'h0, 1'b0, 0, 0, 32'h0);
        run_txn(2, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1, 0, 0, 32'h0BAD_CAFE);
        test_back_to_back();
        test_reset_rsp();
        test_random_arb();
        test_random_txn();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
